// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the IN-instruction input controller.
// Holds the controller state encoding, default bus widths and the switch
// zero-extension helper used when a captured value is returned.
package io_pkg;

  localparam int SW_WIDTH_DEF   = 11;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } io_state_t;

  // Helper is sized by the package default widths.
  function automatic logic [DATA_WIDTH_DEF-1:0] zext_sw(input logic [SW_WIDTH_DEF-1:0] sw);
    logic [DATA_WIDTH_DEF-1:0] ext;
    ext = '0;
    ext[SW_WIDTH_DEF-1:0] = sw;
    return ext;
  endfunction

endpackage

// File: rtl/io_input_ctrl_sync_edge.sv
// sync_edge: two-flop synchronizer with edge detection on the synchronized level.
// Ports: clk, rst_n (async active-low), d (async level in),
//        level (synchronized), rise/fall (one-cycle pulses vs. previous level).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: four-phase Req/Ack feeder for the IN instruction; prompts on
// IOLED, captures FPGA_Switches on a fresh button press, returns it zero-extended.
// Ports: CLK, Reset (async active-low), Req, Button, FPGA_Switches in;
//        Data, Ack, Stall, IOLED, TimedOut out (all registered).
// Optional: define IO_TIMEOUT_EN to abandon WAIT_PRESS after TIMEOUT_CYCLES
// and return DEFAULT_VALUE with TimedOut=1; otherwise waits forever.
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int                    SW_WIDTH       = SW_WIDTH_DEF,
  parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned           TIMEOUT_CYCLES = 50000000,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE  = '0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic                  Button,
  input  logic [SW_WIDTH-1:0]   FPGA_Switches,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  Ack,
  output logic                  Stall,
  output logic                  IOLED,
  output logic                  TimedOut
);

  io_state_t state;
  logic      req_q;
  logic      btn_lvl;
  logic      btn_rise;
  logic      unused_btn_fall;
  logic      timeout_hit;

  // Req comes from a clock derived from CLK, so one register is enough.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) req_q <= 1'b0;
    else        req_q <= Req;
  end

  sync_edge u_btn_sync (
    .clk   (CLK),
    .rst_n (Reset),
    .d     (Button),
    .level (btn_lvl),
    .rise  (btn_rise),
    .fall  (unused_btn_fall)
  );

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt;

  // to_cnt counts completed WAIT_PRESS cycles; expiry fires on the
  // TIMEOUT_CYCLES-th edge spent waiting.
  assign timeout_hit = (state == WAIT_PRESS) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      to_cnt <= '0;
    else if (state == WAIT_PRESS && req_q && !btn_rise && !timeout_hit)
      to_cnt <= to_cnt + CNT_W'(1);
    else
      to_cnt <= '0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Data     <= '0;
      Ack      <= 1'b0;
      Stall    <= 1'b0;
      IOLED    <= 1'b0;
      TimedOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_q) begin
            Stall <= 1'b1;
            IOLED <= 1'b1;
            // A press already held when the request arrives must be released first.
            state <= btn_lvl ? ARM : WAIT_PRESS;
          end
        end
        ARM: begin
          if (!req_q) begin
            Stall <= 1'b0;
            IOLED <= 1'b0;
            state <= IDLE;
          end else if (!btn_lvl) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!req_q) begin
            Stall <= 1'b0;
            IOLED <= 1'b0;
            state <= IDLE;
          end else if (btn_rise) begin
            // Press beats a coincident timeout expiry.
            Data     <= zext_sw(FPGA_Switches);
            TimedOut <= 1'b0;
            IOLED    <= 1'b0;
            state    <= WAIT_RELEASE;
          end else if (timeout_hit) begin
            Data     <= DEFAULT_VALUE;
            TimedOut <= 1'b1;
            IOLED    <= 1'b0;
            Stall    <= 1'b0;
            Ack      <= 1'b1;
            state    <= DONE;
          end
        end
        WAIT_RELEASE: begin
          if (!req_q) begin
            Stall <= 1'b0;
            state <= IDLE;
          end else if (!btn_lvl) begin
            Stall <= 1'b0;
            Ack   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!req_q) begin
            Ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Ack   <= 1'b0;
          Stall <= 1'b0;
          IOLED <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
